// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: state encoding and default timing constants for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT} state_e;
  localparam int RST_CYCLES_DEF = 16;
  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int LOCK_TIMEOUT_DEF = 50000;
  localparam int MAX_RETRIES_DEF = 3;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL status/control and system reset signals of the sequencer
interface pll_reset_sequencer_if;
  logic pll_locked;
  logic soft_reset_req;
  logic pll_rst;
  logic sys_reset;
  logic ready;
  logic fault;
  logic [2:0] retry_count;
  logic [7:0] lock_lost_count;
  modport master (output pll_locked, soft_reset_req,
                  input pll_rst, sys_reset, ready, fault, retry_count, lock_lost_count);
  modport slave (input pll_locked, soft_reset_req,
                 output pll_rst, sys_reset, ready, fault, retry_count, lock_lost_count);
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop bit synchroniser with asynchronous active-low clear
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= '0;
    else s_q <= {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, waits for debounced lock with retries, then releases system reset
import pll_seq_pkg::*;
module pll_reset_sequencer #(
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int MAX_RETRIES = MAX_RETRIES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  pll_reset_sequencer_if.slave bus
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] retry_q, retry_d;
  logic [7:0] lost_q, lost_d;
  logic pll_rst_q, sys_reset_q, ready_q, fault_q;
  logic locked_s;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d_i(bus.pll_locked), .q_o(locked_s));
  // next state, shared counter and retry/loss bookkeeping; soft reset overrides everything
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d = lost_q;
    case (state_q)
      RESET_PLL: state_d = (cnt_q == CNT_W'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK:
        if (locked_s) state_d = STABILIZE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 3'd1;
          state_d = (retry_d == 3'(MAX_RETRIES)) ? FAULT : RESET_PLL;
        end
      STABILIZE: state_d = !locked_s ? WAIT_LOCK : (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) ? RUN : STABILIZE;
      RUN: begin
        retry_d = '0;
        if (!locked_s) begin
          state_d = RESET_PLL;
          lost_d = lost_q + {7'd0, lost_q != 8'hff};
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = RESET_PLL;
    endcase
    if (bus.soft_reset_req) begin
      state_d = RESET_PLL;
      retry_d = '0;
      lost_d = lost_q;
    end
    cnt_d = (state_d != state_q || bus.soft_reset_req) ? '0 : cnt_q + CNT_W'(1);
  end
  // state, counter and outputs decoded from the next state so they move together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RESET_PLL;
      cnt_q <= '0;
      retry_q <= '0;
      lost_q <= '0;
      pll_rst_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      lost_q <= lost_d;
      pll_rst_q <= state_d inside {RESET_PLL, FAULT};
      sys_reset_q <= state_d != RUN;
      ready_q <= state_d == RUN;
      fault_q <= state_d == FAULT;
    end
  assign bus.pll_rst = pll_rst_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.ready = ready_q;
  assign bus.fault = fault_q;
  assign bus.retry_count = retry_q;
  assign bus.lock_lost_count = lost_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard of expected output-change events for the PLL reset sequencer
module tb_pll_reset_sequencer;
  typedef struct {int cyc; logic [14:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t sb[$];
  logic [7:0] lost_m = 8'd0;
  pll_reset_sequencer_if bus ();
  pll_reset_sequencer #(.RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(20), .MAX_RETRIES(2), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [14:0] e(bit pr, bit sr, bit rd, bit ft, logic [2:0] rc, logic [7:0] lc);
    return {pr, sr, rd, ft, rc, lc};
  endfunction
  task automatic push(int c, logic [14:0] v);
    ev_t x;
    x.cyc = c;
    x.v = v;
    sb.push_back(x);
  endtask
  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic relock();
    int c;
    c = cyc;
    bus.pll_locked = 1'b1;
    push(c + 11, e(0, 0, 1, 0, 3'd0, lost_m));
    wait_to(c + 12);
  endtask
  task automatic drop_lock();
    int c;
    c = cyc;
    bus.pll_locked = 1'b0;
    lost_m = (lost_m == 8'd255) ? 8'd255 : lost_m + 8'd1;
    push(c + 3, e(1, 1, 0, 0, 3'd0, lost_m));
    push(c + 7, e(0, 1, 0, 0, 3'd0, lost_m));
    wait_to(c + 8);
  endtask
  // monitor: every change of the output vector must match the next scoreboard entry
  initial begin
    logic [14:0] cur, prev;
    ev_t x;
    prev = 'x;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      cur = {bus.pll_rst, bus.sys_reset, bus.ready, bus.fault, bus.retry_count, bus.lock_lost_count};
      if (cur !== prev) begin
        prev = cur;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc %0d outs got %h want no change", cyc, cur);
        end else begin
          x = sb.pop_front();
          if ((x.cyc != -1 && x.cyc != cyc) || x.v !== cur) begin
            errors++;
            $display("FAIL event cyc got %0d want %0d outs got %h want %h", cyc, x.cyc, cur, x.v);
          end
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc got %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int c, r;
    bus.pll_locked = 1'b0;
    bus.soft_reset_req = 1'b0;
    push(-1, e(1, 1, 0, 0, 3'd0, 8'd0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(r + 4, e(0, 1, 0, 0, 3'd0, 8'd0));
    wait_to(r + 10);
    relock();
    wait_to(cyc + 5);
    c = cyc;
    bus.pll_locked = 1'b0;
    lost_m = 8'd1;
    push(c + 3, e(1, 1, 0, 0, 3'd0, 8'd1));
    push(c + 7, e(0, 1, 0, 0, 3'd0, 8'd1));
    push(c + 27, e(1, 1, 0, 0, 3'd1, 8'd1));
    push(c + 31, e(0, 1, 0, 0, 3'd1, 8'd1));
    push(c + 51, e(1, 1, 0, 1, 3'd2, 8'd1));
    wait_to(c + 151);
    c = cyc;
    bus.soft_reset_req = 1'b1;
    push(c + 1, e(1, 1, 0, 0, 3'd0, 8'd1));
    push(c + 5, e(0, 1, 0, 0, 3'd0, 8'd1));
    @(negedge clk);
    bus.soft_reset_req = 1'b0;
    wait_to(c + 8);
    relock();
    wait_to(cyc + 2);
    drop_lock();
    c = cyc;
    bus.pll_locked = 1'b1;
    wait_to(c + 6);
    bus.pll_locked = 1'b0;
    wait_to(c + 9);
    bus.pll_locked = 1'b1;
    push(c + 20, e(0, 0, 1, 0, 3'd0, lost_m));
    wait_to(c + 21);
    repeat (300) begin
      drop_lock();
      relock();
    end
    c = cyc;
    bus.pll_locked = 1'b0;
    push(c + 3, e(1, 1, 0, 0, 3'd0, 8'd255));
    push(c + 9, e(0, 1, 0, 0, 3'd0, 8'd255));
    wait_to(c + 4);
    bus.soft_reset_req = 1'b1;
    @(negedge clk);
    bus.soft_reset_req = 1'b0;
    wait_to(c + 10);
    relock();
    drop_lock();
    c = cyc;
    bus.pll_locked = 1'b1;
    wait_to(c + 6);
    @(posedge clk);
    #1;
    lost_m = 8'd0;
    push(cyc, e(1, 1, 0, 0, 3'd0, 8'd0));
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(r + 4, e(0, 1, 0, 0, 3'd0, 8'd0));
    push(r + 24, e(1, 1, 0, 0, 3'd1, 8'd0));
    push(r + 28, e(0, 1, 0, 0, 3'd1, 8'd0));
    push(r + 48, e(1, 1, 0, 0, 3'd0, 8'd0));
    push(r + 52, e(0, 1, 0, 0, 3'd0, 8'd0));
    push(r + 80, e(0, 0, 1, 0, 3'd0, 8'd0));
    wait_to(r + 47);
    bus.soft_reset_req = 1'b1;
    @(negedge clk);
    bus.soft_reset_req = 1'b0;
    wait_to(r + 69);
    bus.pll_locked = 1'b1;
    wait_to(r + 95);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
